lms_coef_update: RTL and testbench
==================================

# lms_coef_update

Coefficient-update stage of the LMS adaptive filter. Sits directly downstream of the error calculator: on each strobed sample it takes the error value and the aligned input sample, then serially updates all tap weights with w[k] += mu·e·x[k]. It uses one shared multiplier and saturating arithmetic, and publishes the new coefficient vector to the FIR stage. Step size mu is a power of two, 2^-SHIFT.

## Interface
- TAPS, 8, number of filter taps / coefficients
- DW, 16, width of sample and error (signed)
- CW, 16, width of each coefficient (signed)
- SHIFT, 20, arithmetic right shift applied to e·x (mu = 2^-SHIFT)
- clk_i  in  1  single clock; all logic on rising edge
- rst_n_i  in  1  reset, synchronous, active-low
- sample_valid_i  in  1  strobe; error_i and x_i valid this cycle
- x_i  in  DW  signed newest input sample, already aligned to error_i by the caller
- error_i  in  DW  signed error from the error calculator
- coef_o  out  TAPS*CW  packed weights; w[k] = coef_o[k*CW +: CW]
- coef_valid_o  out  1  one-cycle pulse: coef_o holds a complete, consistent update
- busy_o  out  1  high whenever the FSM is not IDLE
- overrun_o  out  1  sticky; a strobe arrived while busy

## Operation
- Reset (rst_n_i low at an edge) forces the following, regardless of state:
  - all w[k] = 0 and all tap-line x[k] = 0
  - error latch = 0, product register = 0, k = 0
  - FSM returns to IDLE
  - coef_valid_o = 0, busy_o = 0, overrun_o = 0
- FSM states: IDLE, MUL, ACC, DONE.
- IDLE with sample_valid_i = 1 (accept):
  - tap line shifts: x[0] <= x_i, x[j] <= x[j-1]; x[TAPS-1] is discarded
  - error_i is latched, k <= 0, state moves to MUL
- MUL: prod <= e_lat * x[k] (full 2·DW signed product); state moves to ACC.
- ACC:
  - w[k] <= sat_CW(w[k] + (prod >>> SHIFT))
  - if k == TAPS-1, state moves to DONE; otherwise k <= k+1 and state moves to MUL
- DONE: coef_valid_o = 1 for this single cycle; state moves to IDLE.
- Arithmetic rules:
  - the shift is arithmetic, so rounding is floor (toward minus infinity)
  - the sum is formed at 2·DW+1 bits and then saturated to [-2^(CW-1), 2^(CW-1)-1]; no wrap-around
- sample_valid_i in any state other than IDLE (including DONE):
  - the strobe is ignored: no shift and no latch
  - overrun_o <= 1 and holds until reset
- coef_o is driven directly from the weight registers and changes mid-update. Consumers sample it only on coef_valid_o.

## Timing
- Accept edge = edge 0.
- w[k] is written at edge 2k+2.
- DONE is entered at edge 2·TAPS; coef_valid_o is high for the cycle after that edge.
- IDLE is reached at edge 2·TAPS+1; a strobe is accepted again from that edge.
- Throughput: one sample per 2·TAPS+1 cycles (17 for TAPS = 8).
- busy_o is high from after edge 0 through edge 2·TAPS+1 (registered state decode).
- Reset asserted mid-update discards the partial update: weights are zeroed, not restored.
- All outputs are registered or pure decodes of registers; there is no combinational path from inputs to outputs.

## Structure
- Shared package lms_pkg holds:
  - default DW, CW, TAPS, SHIFT
  - FSM state typedef/encoding
  - saturation function sat_cw
- One natural sub-module, lms_sat_acc: combinational shift + add + saturate for one tap, instanced once.
- The FSM, tap line, weight array and multiplier stay in the top module.

## Test plan
All scenarios use the default parameters (TAPS = 8, SHIFT = 20).
- Reset: hold rst_n_i low for 3 edges -> coef_o = 0, busy_o = 0, coef_valid_o = 0, overrun_o = 0.
- Single update: x = 16384, e = 16384 -> w[0] = 256, w[1..7] = 0. coef_valid_o is high exactly in the cycle after edge 16; busy_o is low after edge 17.
- Sign and floor:
  - x = -16384, e = 16384 -> w[0] = -256
  - fresh reset, x = 1, e = 1 -> w[0] = 0
  - fresh reset, x = -1, e = 1 -> w[0] = -1
- Saturation: 40 strobes with x = -32768, e = -32768 (+1024 per tap per update) -> w[0] climbs 1024, 2048, ... and clamps at 32767. No tap ever goes negative.
- Overrun: strobe at edge 0, second strobe at edge 5 -> overrun_o = 1 from edge 6. Coefficients equal the single-strobe result, and only one coef_valid_o pulse occurs.
- Reset mid-update: strobe at edge 0, rst_n_i low at edge 5 -> all coef_o = 0 and IDLE after edge 5, with no coef_valid_o pulse.

Source files
------------

// File: rtl/lms_pkg.sv
// Shared widths, FSM encoding and saturation helper
// for the LMS coefficient-update stage.
package lms_pkg;

    localparam int LMS_TAPS  = 8;
    localparam int LMS_DW    = 16;
    localparam int LMS_CW    = 16;
    localparam int LMS_SHIFT = 20;
    localparam int LMS_SW    = 2 * LMS_DW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_ACC,
        S_DONE
    } lms_state_e;

    // In range when every bit above the CW sign bit matches it
    function automatic logic signed [LMS_CW-1:0] sat_cw(
        input logic signed [LMS_SW-1:0] v
    );
        logic signed [LMS_CW-1:0] r;
        if (&v[LMS_SW-1:LMS_CW-1] || ~|v[LMS_SW-1:LMS_CW-1])
            r = v[LMS_CW-1:0];
        else if (v[LMS_SW-1])
            r = {1'b1, {(LMS_CW-1){1'b0}}};
        else
            r = {1'b0, {(LMS_CW-1){1'b1}}};
        return r;
    endfunction

endpackage

// File: rtl/lms_coef_update_if.sv
// Sample strobe in, coefficient vector and status out
// for the LMS coefficient-update stage.
interface lms_coef_update_if
    import lms_pkg::*;
#(
    parameter int TAPS = LMS_TAPS,
    parameter int DW   = LMS_DW,
    parameter int CW   = LMS_CW
);

    logic                   sample_valid_i;
    logic signed [DW-1:0]   x_i;
    logic signed [DW-1:0]   error_i;
    logic [TAPS*CW-1:0]     coef_o;
    logic                   coef_valid_o;
    logic                   busy_o;
    logic                   overrun_o;

    modport master (
        output sample_valid_i, x_i, error_i,
        input  coef_o, coef_valid_o, busy_o, overrun_o
    );

    modport slave (
        input  sample_valid_i, x_i, error_i,
        output coef_o, coef_valid_o, busy_o, overrun_o
    );

endinterface

// File: rtl/lms_sat_acc.sv
// One-tap weight step: floor-shift the product, add,
// and clamp to the coefficient range.
module lms_sat_acc
    import lms_pkg::*;
#(
    parameter int DW    = LMS_DW,
    parameter int CW    = LMS_CW,
    parameter int SHIFT = LMS_SHIFT
) (
    input  logic signed [CW-1:0]   w_i,
    input  logic signed [2*DW-1:0] prod_i,
    output logic signed [CW-1:0]   w_o
);

    localparam int SW = 2 * DW + 1;

    logic signed [2*DW-1:0] step;
    logic signed [SW-1:0]   sum;

    assign step = prod_i >>> SHIFT;
    assign sum  = {step[2*DW-1], step}
                + {{(SW-CW){w_i[CW-1]}}, w_i};
    assign w_o  = sat_cw(sum);

endmodule

// File: rtl/lms_coef_update.sv
// LMS coefficient update: serial w[k] += mu*e*x[k]
// through one shared multiplier, two cycles per tap.
module lms_coef_update
    import lms_pkg::*;
#(
    parameter int TAPS  = LMS_TAPS,
    parameter int DW    = LMS_DW,
    parameter int CW    = LMS_CW,
    parameter int SHIFT = LMS_SHIFT
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    lms_coef_update_if.slave bus
);

    localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;

    lms_state_e             state_q;
    lms_state_e             state_d;
    logic signed [DW-1:0]   x_q [TAPS];
    logic signed [CW-1:0]   w_q [TAPS];
    logic signed [DW-1:0]   e_q;
    logic signed [2*DW-1:0] prod_q;
    logic [KW-1:0]          k_q;
    logic                   overrun_q;
    logic signed [CW-1:0]   w_new;
    logic                   accept;
    logic                   last;

    assign accept = (state_q == S_IDLE) && bus.sample_valid_i;
    assign last   = (k_q == KW'(TAPS - 1));

    lms_sat_acc #(
        .DW    (DW),
        .CW    (CW),
        .SHIFT (SHIFT)
    ) u_sat_acc (
        .w_i    (w_q[k_q]),
        .prod_i (prod_q),
        .w_o    (w_new)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.sample_valid_i) state_d = S_MUL;
            S_MUL:  state_d = S_ACC;
            S_ACC:  state_d = last ? S_DONE : S_MUL;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Reset discards any partial update rather than restoring
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            e_q       <= '0;
            prod_q    <= '0;
            k_q       <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (bus.sample_valid_i && state_q != S_IDLE)
                overrun_q <= 1'b1;
            if (accept) begin
                x_q[0] <= bus.x_i;
                for (int i = 1; i < TAPS; i++)
                    x_q[i] <= x_q[i-1];
                e_q <= bus.error_i;
                k_q <= '0;
            end
            if (state_q == S_MUL)
                prod_q <= (2*DW)'(e_q) * (2*DW)'(x_q[k_q]);
            if (state_q == S_ACC) begin
                w_q[k_q] <= w_new;
                if (!last)
                    k_q <= k_q + KW'(1);
            end
        end
    end

    always_comb begin
        bus.coef_o = '0;
        for (int i = 0; i < TAPS; i++)
            bus.coef_o[i*CW +: CW] = w_q[i];
    end

    assign bus.coef_valid_o = (state_q == S_DONE);
    assign bus.busy_o       = (state_q != S_IDLE);
    assign bus.overrun_o    = overrun_q;

endmodule

// File: tb/tb_lms_coef_update.sv
// Directed vector bench for lms_coef_update:
// single updates, floor rounding, saturation, overrun, mid-update reset.
module tb_lms_coef_update;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    lms_coef_update_if bus ();

    lms_coef_update dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        int x;
        int e;
        int w0;
        int w1;
    } vec_t;

    vec_t vt [6];

    function automatic int get_w(int k);
        logic signed [15:0] v;
        v = bus.coef_o[k*16 +: 16];
        return int'(v);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.sample_valid_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_update(int x, int e);
        int pulses;
        int pulse_at;
        int busy0;
        int busy16;
        int busy17;
        bus.x_i = 16'(x);
        bus.error_i = 16'(e);
        bus.sample_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_valid_i = 1'b0;
        busy0 = int'(bus.busy_o);
        pulses = 0;
        pulse_at = -1;
        busy16 = 0;
        busy17 = 1;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1;
            if (bus.coef_valid_o) begin
                pulses++;
                pulse_at = i;
            end
            if (i == 16) busy16 = int'(bus.busy_o);
            if (i == 17) busy17 = int'(bus.busy_o);
        end
        chk("busy_after_accept", busy0, 1);
        chk("valid_pulses", pulses, 1);
        chk("valid_edge", pulse_at, 16);
        chk("busy_edge16", busy16, 1);
        chk("busy_edge17", busy17, 0);
    endtask

    initial begin
        int nz;
        int neg;
        int pulses;
        int pulse_at;
        int exp_w;

        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.sample_valid_i = 1'b0;
        bus.x_i = '0;
        bus.error_i = '0;

        vt[0] = '{rst: 1, x:  16384, e: 16384, w0:  256, w1: 0};
        vt[1] = '{rst: 1, x: -16384, e: 16384, w0: -256, w1: 0};
        vt[2] = '{rst: 1, x:      1, e:     1, w0:    0, w1: 0};
        vt[3] = '{rst: 1, x:     -1, e:     1, w0:   -1, w1: 0};
        vt[4] = '{rst: 1, x:  32767, e: 32767, w0: 1023, w1: 0};
        vt[5] = '{rst: 0, x: -32768, e: -32768, w0: 2047, w1: -1024};

        do_reset();
        chk("rst_coef_zero", int'(bus.coef_o == '0), 1);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_valid", int'(bus.coef_valid_o), 0);
        chk("rst_overrun", int'(bus.overrun_o), 0);

        for (int v = 0; v < 6; v++) begin
            if (vt[v].rst) do_reset();
            run_update(vt[v].x, vt[v].e);
            chk($sformatf("vec%0d_w0", v), get_w(0), vt[v].w0);
            chk($sformatf("vec%0d_w1", v), get_w(1), vt[v].w1);
            nz = 0;
            for (int k = 2; k < 8; k++)
                if (get_w(k) != 0) nz++;
            chk($sformatf("vec%0d_rest_zero", v), nz, 0);
            chk($sformatf("vec%0d_overrun", v), int'(bus.overrun_o), 0);
        end

        // Saturation: +1024 per tap per update, clamp at 32767
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            run_update(-32768, -32768);
            exp_w = (1024 * n > 32767) ? 32767 : 1024 * n;
            chk($sformatf("sat_w0_n%0d", n), get_w(0), exp_w);
            neg = 0;
            for (int k = 0; k < 8; k++)
                if (get_w(k) < 0) neg++;
            chk($sformatf("sat_nonneg_n%0d", n), neg, 0);
        end
        nz = 0;
        for (int k = 0; k < 8; k++)
            if (get_w(k) != 32767) nz++;
        chk("sat_all_clamped", nz, 0);

        // Overrun: second strobe at edge 5 is ignored
        do_reset();
        bus.x_i = 16'(16384);
        bus.error_i = 16'(16384);
        bus.sample_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_before", int'(bus.overrun_o), 0);
        bus.x_i = 16'(999);
        bus.error_i = 16'(999);
        bus.sample_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_valid_i = 1'b0;
        pulses = 0;
        pulse_at = -1;
        @(posedge clk);
        #1;
        chk("ovr_edge6", int'(bus.overrun_o), 1);
        for (int i = 7; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.coef_valid_o) begin
                pulses++;
                pulse_at = i;
            end
        end
        chk("ovr_pulses", pulses, 1);
        chk("ovr_pulse_edge", pulse_at, 16);
        chk("ovr_w0", get_w(0), 256);
        chk("ovr_w1", get_w(1), 0);
        chk("ovr_sticky", int'(bus.overrun_o), 1);

        // Reset at edge 5 wipes the already-written w[0]
        do_reset();
        bus.x_i = 16'(16384);
        bus.error_i = 16'(16384);
        bus.sample_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_w0_written", get_w(0), 256);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_coef_zero", int'(bus.coef_o == '0), 1);
        chk("mid_busy", int'(bus.busy_o), 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.coef_valid_o) pulses++;
        end
        chk("mid_no_pulse", pulses, 0);
        chk("mid_still_zero", int'(bus.coef_o == '0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
